// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch constants (NOP encoding) and fetch request/response/entry types
package riscv_pkg;
  localparam logic [31:0] InstrNop = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] addr;
  } fetch_req_t;
  typedef struct packed {
    logic [31:0] data;
  } fetch_rsp_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH circular buffer with sync flush, push/pop and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    do_push = push_i && (count_q != CW'(DEPTH) || pop_i);
    do_pop = pop_i && count_q != '0;
    wr_d = flush_i ? '0 : do_push ? inc(wr_q) : wr_q;
    rd_d = flush_i ? '0 : do_pop ? inc(rd_q) : rd_q;
    count_d = flush_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end
  assign pop_data_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, credit-limited imem requester and decode-side FIFO; IFETCH_MISALIGN_CHECK_EN adds sticky o_fetch_misaligned
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic            o_fetch_misaligned
`endif
);
  logic [XLEN-1:0] pc_q, pc_d, redirect_pc, tag;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_q, drop_d, fifo_count, tag_count;
  logic [2*XLEN-1:0] head;
  logic req_fire, rsp_keep, pop, halt;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  assign redirect_pc = i_redirect_pc;
  assign misaligned_d = i_redirect_valid ? |i_redirect_pc[1:0] : misaligned_q;
  assign halt = misaligned_q;
  assign o_fetch_misaligned = misaligned_q;
  always_ff @(posedge clk) begin
    if (rst) misaligned_q <= 1'b0;
    else misaligned_q <= misaligned_d;
  end
`else
  assign redirect_pc = i_redirect_pc & ~XLEN'(3);
  assign halt = 1'b0;
`endif
  assign o_imem_req_valid = !rst && !i_redirect_valid && !halt
                          && (int'(outstanding_q) + int'(fifo_count) < DEPTH);
  assign o_imem_req_addr = pc_q;
  assign req_fire = o_imem_req_valid && i_imem_req_ready;
  assign rsp_keep = i_imem_rsp_valid && drop_q == '0 && !i_redirect_valid;
  assign o_instr_valid = fifo_count != '0;
  assign pop = o_instr_valid && i_instr_ready;
  assign o_instruction = o_instr_valid ? head[XLEN-1:0] : XLEN'(InstrNop);
  assign o_pc = o_instr_valid ? head[2*XLEN-1:XLEN] : '0;
  always_comb begin
    pc_d = i_redirect_valid ? redirect_pc : req_fire ? pc_q + XLEN'(4) : pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
    drop_d = i_redirect_valid ? outstanding_q - CW'(i_imem_rsp_valid)
           : (i_imem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      outstanding_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_instr_fifo (
    .clk,
    .rst,
    .flush_i(i_redirect_valid),
    .push_i(rsp_keep),
    .push_data_i({tag, i_imem_rsp_data}),
    .pop_i(pop),
    .pop_data_o(head),
    .count_o(fifo_count)
  );
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_fifo (
    .clk,
    .rst,
    .flush_i(1'b0),
    .push_i(req_fire),
    .push_data_i(pc_q),
    .pop_i(i_imem_rsp_valid),
    .pop_data_o(tag),
    .count_o(tag_count)
  );
  a_credit: assert property (@(posedge clk) disable iff (rst)
    int'(outstanding_q) + int'(fifo_count) <= DEPTH);
  a_rsp: assert property (@(posedge clk) disable iff (rst)
    i_imem_rsp_valid |-> outstanding_q != '0);
  a_tag: assert property (@(posedge clk) disable iff (rst)
    tag_count == outstanding_q);
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboarded directed bench with a latency-configurable in-order memory model
module tb_instruction_fetch;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int due;
  } mem_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst;
  logic i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic o_imem_req_valid;
  logic i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic o_instr_valid;
  logic i_instr_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic o_fetch_misaligned;
`endif
  exp_t exp_q[$];
  mem_t mem_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, lat = 1, last_due = 0, fire_cnt = 0, k, f0;
  logic [31:0] exp_next = '0, last_addr = '0;
  instruction_fetch dut (
    .clk(clk),
    .rst(rst),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_req_addr(o_imem_req_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data),
    .o_instr_valid(o_instr_valid),
    .i_instr_ready(i_instr_ready),
    .o_instruction(o_instruction),
    .o_pc(o_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .o_fetch_misaligned(o_fetch_misaligned)
`endif
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      mem_q.delete();
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data = mem_f(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data = '0;
    end
  end
  initial forever begin
    exp_t e;
    mem_t m;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      exp_next = '0;
      last_due = 0;
    end else begin
      if (o_instr_valid && i_instr_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_pop_pc", o_pc, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("sb_pc", o_pc, e.pc);
          chk("sb_instr", o_instruction, e.instr);
        end
      end
      if (i_redirect_valid) begin
        chk("redirect_no_req", 32'(o_imem_req_valid), 32'd0);
        exp_q.delete();
        exp_next = i_redirect_pc & ~32'h3;
      end
      if (o_imem_req_valid && i_imem_req_ready) begin
        chk("req_addr", o_imem_req_addr, exp_next);
        e.pc = exp_next;
        e.instr = mem_f(exp_next);
        exp_q.push_back(e);
        m.addr = o_imem_req_addr;
        m.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = m.due;
        mem_q.push_back(m);
        last_addr = o_imem_req_addr;
        exp_next += 32'd4;
        fire_cnt++;
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    i_imem_req_ready = 1'b1;
    i_instr_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_instruction", o_instruction, NOP);
    chk("rst_pc", o_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!o_instr_valid && n < maxc) begin
      @(negedge clk);
      #3;
      n++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    i_imem_req_ready = 1'b1;
    i_instr_ready = 1'b1;
    lat = 1;
    do_reset();
    #3;
    chk("t1_req_valid", 32'(o_imem_req_valid), 32'd1);
    chk("t1_req_addr", o_imem_req_addr, 32'h0);
    @(negedge clk); #3;
    chk("t1_latency_empty", 32'(o_instr_valid), 32'd0);
    @(negedge clk); #3;
    chk("t1_first_valid", 32'(o_instr_valid), 32'd1);
    chk("t1_first_pc", o_pc, 32'h0);
    chk("t1_first_instr", o_instruction, mem_f(32'h0));
    @(negedge clk); #3;
    chk("t1_second_pc", o_pc, 32'h4);
    @(negedge clk); #3;
    chk("t1_third_pc", o_pc, 32'h8);
    repeat (6) @(negedge clk);
    lat = 1;
    do_reset();
    i_instr_ready = 1'b0;
    f0 = fire_cnt;
    repeat (9) @(negedge clk);
    #3;
    chk("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
    chk("stall_fires", 32'(fire_cnt - f0), 32'd4);
    chk("stall_head_valid", 32'(o_instr_valid), 32'd1);
    chk("stall_head_pc", o_pc, 32'h0);
    @(negedge clk);
    i_instr_ready = 1'b1;
    f0 = fire_cnt;
    #3;
    k = 0;
    while (fire_cnt == f0 && k < 10) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk("resume_cycles", 32'(k), 32'd1);
    chk("resume_addr", last_addr, 32'h10);
    @(negedge clk);
    @(negedge clk); #3;
    chk("drain_fourth_pc", o_pc, 32'hC);
    repeat (4) @(negedge clk);
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    i_imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("hold_valid", 32'(o_imem_req_valid), 32'd1);
      chk("hold_addr", o_imem_req_addr, 32'h8);
      @(negedge clk);
    end
    i_imem_req_ready = 1'b1;
    #3;
    chk("hold_release_addr", o_imem_req_addr, 32'h8);
    repeat (4) @(negedge clk);
    lat = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h100;
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #3;
    wait_valid(20, k);
    chk("redir_wait", 32'(k), 32'd4);
    chk("redir_first_pc", o_pc, 32'h100);
    repeat (6) @(negedge clk);
    lat = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h300;
    @(negedge clk);
    i_redirect_pc = 32'h400;
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #3;
    wait_valid(20, k);
    chk("b2b_wait", 32'(k), 32'd4);
    chk("b2b_first_pc", o_pc, 32'h400);
    repeat (6) @(negedge clk);
    lat = 1;
    do_reset();
    repeat (5) @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h40;
    #3;
    chk("rc_hs_valid", 32'(o_instr_valid), 32'd1);
    chk("rc_hs_pc", o_pc, 32'hC);
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #3;
    chk("rc_flush_valid", 32'(o_instr_valid), 32'd0);
    chk("rc_flush_instr", o_instruction, NOP);
    chk("rc_flush_pc", o_pc, 32'h0);
    wait_valid(20, k);
    chk("rc_wait", 32'(k), 32'd2);
    chk("rc_first_pc", o_pc, 32'h40);
    repeat (4) @(negedge clk);
`ifdef IFETCH_MISALIGN_CHECK_EN
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h102;
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #3;
    chk("mis_flag_set", 32'(o_fetch_misaligned), 32'd1);
    chk("mis_no_req", 32'(o_imem_req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk); #3;
    chk("mis_no_req_hold", 32'(o_imem_req_valid), 32'd0);
    @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h200;
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #3;
    chk("mis_flag_clear", 32'(o_fetch_misaligned), 32'd0);
    chk("mis_resume_valid", 32'(o_imem_req_valid), 32'd1);
    chk("mis_resume_addr", o_imem_req_addr, 32'h200);
    repeat (4) @(negedge clk);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
